// File: rtl/bitvector_deserializer_pkg.sv
// bitvector_deserializer_pkg: shared state type and width helper for the serial-to-word feeder
package bitvector_deserializer_pkg;
  typedef enum logic {FILL, FULL} state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/bitvector_deserializer_if.sv
// bitvector_deserializer_if: serial bit input and parallel word output handshakes
interface bitvector_deserializer_if #(parameter int COUNT_OF_BITS = 4);
  import bitvector_deserializer_pkg::*;
  localparam int CNT_W = cnt_w(COUNT_OF_BITS);
  logic clear;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic [COUNT_OF_BITS-1:0] bitvector;
  logic out_valid;
  logic out_ready;
  logic [CNT_W:0] fill_level;
  modport master(output clear, in_bit, in_valid, out_ready,
                 input in_ready, bitvector, out_valid, fill_level);
  modport slave(input clear, in_bit, in_valid, out_ready,
                output in_ready, bitvector, out_valid, fill_level);
endinterface

// File: rtl/bitvector_deserializer.sv
// bitvector_deserializer: packs COUNT_OF_BITS serial bits (first bit -> bit 0) into a held word
module bitvector_deserializer
  import bitvector_deserializer_pkg::*;
#(
  parameter int COUNT_OF_BITS = 4
) (
  input logic clk,
  input logic rst_n,
  bitvector_deserializer_if.slave bus
);
  localparam int CNT_W = cnt_w(COUNT_OF_BITS);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_OF_BITS-1:0] word_q, word_d;
  logic in_xfer, out_xfer, last;
  // in FULL the input follows out_ready so a new word can start in the take cycle
  assign bus.in_ready   = (state_q == FULL) ? bus.out_ready : !bus.clear;
  assign bus.out_valid  = state_q == FULL;
  assign bus.bitvector  = word_q;
  assign bus.fill_level = (state_q == FULL) ? (CNT_W+1)'(COUNT_OF_BITS) : {1'b0, cnt_q};
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = (state_q == FULL) && bus.out_ready;
  assign last     = cnt_q == CNT_W'(COUNT_OF_BITS - 1);
  always_comb begin
    word_d  = word_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_xfer) word_d[cnt_q] = bus.in_bit;
    if (state_q == FILL) begin
      cnt_d   = bus.clear ? '0 : in_xfer ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
      state_d = (in_xfer && last) ? FULL : FILL;
    end else if (out_xfer) begin
      cnt_d   = in_xfer ? CNT_W'(1) : '0;
      state_d = FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end
endmodule

// File: tb/tb_bitvector_deserializer.sv
// tb_bitvector_deserializer: directed and random checks against a queue-based reference model
module tb_bitvector_deserializer;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bitvector_deserializer_if #(.COUNT_OF_BITS(N)) bus();
  bitvector_deserializer #(.COUNT_OF_BITS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int n_checks = 0;
  int n_fail = 0;
  bit mq[$];
  logic m_full = 1'b0;
  logic [N-1:0] m_word = '0;
  logic exp_ready, obs_ready;
  logic [N-1:0] taken[$];
  function automatic logic [2:0] exp_fill();
    return m_full ? 3'(N) : 3'(mq.size());
  endfunction
  task automatic cyc(input logic v, input logic b, input logic r, input logic c);
    bus.in_valid = v;
    bus.in_bit = b;
    bus.out_ready = r;
    bus.clear = c;
    #1;
    obs_ready = bus.in_ready;
    exp_ready = m_full ? r : !c;
    if (bus.out_valid && r) taken.push_back(bus.bitvector);
    @(posedge clk);
    if (rst_n) begin
      if (m_full) begin
        if (r) begin
          m_full = 1'b0;
          mq.delete();
          if (v) mq.push_back(b);
        end
      end else if (c) mq.delete();
      else if (v) begin
        mq.push_back(b);
        if (mq.size() == N) begin
          for (int i = 0; i < N; i++) m_word[i] = mq[i];
          m_full = 1'b1;
          mq.delete();
        end
      end
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      n_checks++;
      if ({bus.out_valid, obs_ready, bus.bitvector, bus.fill_level} !== {1'b0, 1'b1, 4'b0000, 3'd0}) begin
        n_fail++;
        $display("FAIL reset {valid,ready,vec,fill} got %b exp %b",
                 {bus.out_valid, obs_ready, bus.bitvector, bus.fill_level}, {1'b0, 1'b1, 4'b0000, 3'd0});
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_basic_fill();
    logic [3:0] pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pat[i], 1'b0, 1'b0);
      n_checks++;
      if ({obs_ready, bus.fill_level} !== {1'b1, 3'(i + 1)}) begin
        n_fail++;
        $display("FAIL basic_fill bit%0d {ready,fill} got %b exp %b", i, {obs_ready, bus.fill_level}, {1'b1, 3'(i + 1)});
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.bitvector} !== {1'b1, 4'b1101}) begin
        n_fail++;
        $display("FAIL basic_fill hold%0d {valid,vec} got %b exp %b", i, {bus.out_valid, bus.bitvector}, {1'b1, 4'b1101});
      end
      cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom));
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_fill in_ready while full got %b exp 0", obs_ready);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.fill_level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL basic_fill drain {valid,fill} got %b exp %b", {bus.out_valid, bus.fill_level}, {1'b0, 3'd0});
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] pat = 8'b1000_1111;
    int valid_cycles = 0;
    taken.delete();
    for (int i = 0; i < 9; i++) begin
      cyc(i < 8, i < 8 ? pat[i] : 1'b0, 1'b1, 1'b0);
      if (bus.out_valid) valid_cycles++;
      n_checks++;
      if (obs_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back in_ready cycle %0d got %b exp 1", i, obs_ready);
      end
    end
    n_checks++;
    if (valid_cycles != 2 || taken.size() != 2) begin
      n_fail++;
      $display("FAIL back_to_back valid_cycles got %0d words %0d exp 2 and 2", valid_cycles, taken.size());
    end else begin
      n_checks++;
      if (taken[0] !== 4'b1111 || taken[1] !== 4'b1000) begin
        n_fail++;
        $display("FAIL back_to_back words got %b %b exp 1111 1000", taken[0], taken[1]);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [3:0] pat = 4'b0110;
    for (int i = 0; i < 4; i++) cyc(1'b1, pat[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
      n_checks++;
      if ({obs_ready, bus.out_valid, bus.bitvector, bus.fill_level} !== {1'b0, 1'b1, 4'b0110, 3'd4}) begin
        n_fail++;
        $display("FAIL backpressure {ready,valid,vec,fill} got %b exp %b",
                 {obs_ready, bus.out_valid, bus.bitvector, bus.fill_level}, {1'b0, 1'b1, 4'b0110, 3'd4});
      end
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({obs_ready, bus.out_valid, bus.fill_level} !== {1'b1, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL backpressure release {ready,valid,fill} got %b exp %b",
               {obs_ready, bus.out_valid, bus.fill_level}, {1'b1, 1'b0, 3'd1});
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_clear();
    logic [3:0] pat = 4'b1001;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_ready, bus.fill_level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL clear {ready,fill} got %b exp %b", {obs_ready, bus.fill_level}, {1'b0, 3'd0});
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, pat[i], 1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.bitvector} !== {1'b1, 4'b1001}) begin
      n_fail++;
      $display("FAIL clear word {valid,vec} got %b exp %b", {bus.out_valid, bus.bitvector}, {1'b1, 4'b1001});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({bus.out_valid, bus.bitvector} !== {1'b1, 4'b1001}) begin
      n_fail++;
      $display("FAIL clear in full {valid,vec} got %b exp %b", {bus.out_valid, bus.bitvector}, {1'b1, 4'b1001});
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_async_reset();
    logic [3:0] pat = 4'b0010;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    mq.delete();
    m_full = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.bitvector, bus.fill_level} !== {1'b0, 1'b1, 4'b0000, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset {valid,ready,vec,fill} got %b exp %b",
               {bus.out_valid, bus.in_ready, bus.bitvector, bus.fill_level}, {1'b0, 1'b1, 4'b0000, 3'd0});
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, pat[i], 1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.bitvector} !== {1'b1, 4'b0010}) begin
      n_fail++;
      $display("FAIL async_reset word {valid,vec} got %b exp %b", {bus.out_valid, bus.bitvector}, {1'b1, 4'b0010});
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
      n_checks++;
      if ({obs_ready, bus.out_valid, bus.fill_level} !== {exp_ready, m_full, exp_fill()}) begin
        n_fail++;
        $display("FAIL random cycle %0d {ready,valid,fill} got %b exp %b",
                 i, {obs_ready, bus.out_valid, bus.fill_level}, {exp_ready, m_full, exp_fill()});
      end
      if (m_full) begin
        n_checks++;
        if (bus.bitvector !== m_word) begin
          n_fail++;
          $display("FAIL random cycle %0d bitvector got %b exp %b", i, bus.bitvector, m_word);
        end
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_basic_fill();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bitvector_deserializer.md
Name: bitvector_deserializer

Overview:
Upstream feeder stage for the implication reduction block. Accepts a serial stream of single bits over a valid/ready handshake and assembles COUNT_OF_BITS consecutive bits into one parallel bitvector word. The completed word is held stable on a valid/ready output until the downstream reduction stage takes it. The first bit received lands in bit 0, the head of the reduction chain.

Parameters:
COUNT_OF_BITS, 4, word width in bits; legal range 2..64
CNT_W, $clog2(COUNT_OF_BITS), width of the internal bit-position counter; derived, not overridden

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous; abandons the partially filled word
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  block accepts in_bit this cycle
bitvector  output  COUNT_OF_BITS  assembled word; drives the reducer's bitvector input
out_valid  output  1  bitvector holds a complete word
out_ready  input  1  downstream takes the word this cycle
fill_level  output  CNT_W+1  number of bits held in the word under construction (0..COUNT_OF_BITS)

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, counter=0, bitvector=0, out_valid=0, fill_level=0.
- In FILL, in_ready=1.
- An input transfer occurs on in_valid && in_ready.
- On an input transfer, in_bit is written to bitvector[counter] and the counter increments.
- Bits not yet written are undefined-but-stable. They are zero after reset, and otherwise hold the previous word's values.
- On the transfer that fills the last position (counter==COUNT_OF_BITS-1):
  - counter wraps to 0 and state moves to FULL.
  - out_valid=1 from the next cycle. Latency is 1 cycle from the last bit to word valid.
- In FULL:
  - out_valid=1 and bitvector is held stable until an output transfer (out_valid && out_ready).
  - in_ready = out_ready, which gives a zero-bubble path.
- Output transfer without an input transfer in the same cycle: state returns to FILL and out_valid=0 next cycle.
- Simultaneous output and input transfer in FULL: the word is consumed, in_bit is written to bitvector[0], counter=1, state=FILL.
- Sustained throughput is therefore 1 word per COUNT_OF_BITS cycles with no idle cycle.
- fill_level = counter in FILL; COUNT_OF_BITS in FULL.
- clear=1 in FILL: counter=0 next cycle. in_ready is forced to 0 that cycle, so no bit is accepted.
- clear=1 in FULL: ignored. A completed word is never discarded.
- in_bit is ignored when in_valid=0.
- out_ready is ignored in FILL.
- An asynchronous reset mid-word or mid-hold discards everything immediately; no output transfer is reported.
- Once out_valid rises it stays high until the output transfer (AXI-style rule; no retraction).
- Counter width CNT_W never overflows, because the wrap occurs at COUNT_OF_BITS-1.

Decomposition:
- Shared package: state enum (FILL, FULL) as a typedef, plus a helper function that computes CNT_W for a given width.
- No sub-module is needed. The block is one FSM plus counter plus word register.
- Top-level integration instantiates this block feeding the implication reducer. That pairing is wired in the exercise top, not inside this module.

Test Plan (COUNT_OF_BITS=4):
- Reset check: hold rst_n=0 with random inputs → out_valid=0, in_ready=1, bitvector=4'b0000, fill_level=0.
- Basic fill: send bits 1,0,1,1 on consecutive cycles with out_ready=0 → cycle after 4th bit: out_valid=1, bitvector=4'b1101, in_ready=0; held for 10 cycles unchanged.
- Back-to-back: continuous in_valid=1, out_ready=1, stream 1,1,1,1,0,0,0,1 → two words 4'b1111 then 4'b1000, each out_valid for exactly 1 cycle, in_ready never drops.
- Backpressure: complete word 4'b0110, hold out_ready=0 for 5 cycles while in_valid=1 → no input accepted, bitvector stable. Raise out_ready with in_bit=1 → word taken, fill_level=1 next cycle.
- Clear: send 2 bits, assert clear one cycle, then send 1,0,0,1 → output 4'b1001; the abandoned bits have no effect.
- Async reset mid-word: after 3 bits, pulse rst_n low between clock edges → outputs reset immediately. The next 4 bits 0,1,0,0 produce 4'b0010.
